pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central interlock and forwarding scheduler for the decode stage.
- Tracks destination tags of in-flight instructions in EX, MEM and WB, and generates the decode stall, forwarding selects and decode squash on branch/jump.
- Sequences ECALL: drains the back pipeline, then halts issue.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  5  rs1 index
- id_rs2  in  5  rs2 index
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  destination index
- id_rd_wen  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_ecall  in  1  instruction is ECALL
- es_allowin  in  1  EX accepts; when low, the EX/MEM/WB tags all hold
- br_jmp_flag  in  1  taken branch/jump resolved in EX
- stall_flag  out  1  decode must hold
- flush_id  out  1  squash the decode instruction
- fwd_rs1_sel  out  2  0 regfile, 1 EX, 2 MEM, 3 WB
- fwd_rs2_sel  out  2  same encoding for rs2
- issue  out  1  decode instruction moves to EX this cycle
- halted  out  1  ECALL drain complete
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- One clock domain. Reset is synchronous and active-low: clk and rst_n, sampled on the rising edge of clk.
- Reset values:
  - all tag valids 0
  - FSM = RUN
  - stall_cnt = 0
  - halted = 0
  - all combinational outputs are functions of state, so they are 0/default after reset.
- Tag entry per stage: {v, rd, wen, ld}. An entry with rd==0 or wen==0 never matches.
- match(S, r) = S.v & S.wen & (S.rd != 0) & (S.rd == r).
- Load-use hazard: match(EX, rsX) & EX.ld & rsX_used, for rs1 or rs2.
- stall_flag = id_valid & (load_use | state != RUN) & !br_jmp_flag.
  - A flush overrides the stall.
- flush_id = br_jmp_flag & id_valid.
- issue = id_valid & !stall_flag & !flush_id & es_allowin.
- Forward select per operand: first match in the order EX (only if !EX.ld), MEM, WB; otherwise 0. Selects are driven even when the operand is unused.
- Tag pipeline update when es_allowin=1:
  - WB <= MEM
  - MEM <= EX
  - EX <= issue ? {1, id_rd, id_rd_wen, id_is_load} : bubble (v=0)
- When es_allowin=0, all tags hold. Zero-cycle latency: outputs are combinational on current tags and inputs.
- ECALL FSM:
  - RUN -> DRAIN when issue & id_ecall. The ECALL tag enters EX with wen=0.
  - DRAIN:
    - stall asserted
    - -> HALT when EX.v, MEM.v and WB.v are all 0 at the clock edge
    - br_jmp_flag in DRAIN is ignored: the ECALL is older than any possible branch in EX.
  - HALT: halted=1 and stall asserted permanently, until reset.
- Reset in any state returns the FSM to RUN and clears all tags the same cycle.
- stall_cnt increments by 1 each cycle stall_flag=1, and saturates at all-ones (no wrap).

Test Plan:
- Back-to-back dependency:
  - Stimulus: issue ADD rd=5 (non-load), next cycle a decode instruction with rs1=5 used.
  - Required: fwd_rs1_sel=1, stall_flag=0, issue=1. One cycle later, a reader of x5 sees fwd_rs1_sel=2.
- Load-use:
  - Stimulus: issue LW rd=7, then decode with rs2=7.
  - Required: stall_flag=1 for exactly 1 cycle, then fwd_rs2_sel=2 and issue=1. stall_cnt=1.
- x0 write:
  - Stimulus: issue LW rd=0, then a reader of rs1=0.
  - Required: no stall; fwd_rs1_sel=0.
- Flush over stall:
  - Stimulus: load-use condition present while br_jmp_flag=1.
  - Required: stall_flag=0, flush_id=1, issue=0. The next EX tag is a bubble.
- ECALL drain:
  - Stimulus: issue ECALL with 2 older instructions in MEM/WB.
  - Required: stall_flag=1 throughout DRAIN. halted=1 on the edge when all three stages are invalid (ECALL retires WB after 3 advancing cycles). halted stays 1. Reset returns halted=0.
- Back-pressure and saturation:
  - Stimulus: es_allowin=0 for 4 cycles.
  - Required: tags frozen, forwarding selects unchanged, issue=0.
  - Stimulus: CNT_W=4 with 20 stall cycles.
  - Required: stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage interlock and forwarding scheduler: tracks EX/MEM/WB destination
// tags, produces stall/flush/forward selects, sequences ECALL drain and halt.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd,
   input  logic             id_rd_wen,
   input  logic             id_is_load,
   input  logic             id_ecall,
   input  logic             es_allowin,
   input  logic             br_jmp_flag,
   output logic             stall_flag,
   output logic             flush_id,
   output logic [1:0]       fwd_rs1_sel,
   output logic [1:0]       fwd_rs2_sel,
   output logic             issue,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wen;
      logic       ld;
   } tag_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   tag_t   ex_q, mem_q, wb_q, ex_d;
   state_t state;
   logic   running, br_eff, load_use, drain_done;

   function automatic logic hit(input tag_t t, input logic [4:0] r);
      return t.v & t.wen & (t.rd != 5'd0) & (t.rd == r);
   endfunction

   // A load in EX cannot forward yet, so the search falls through to MEM/WB.
   function automatic logic [1:0] fwd_of(input tag_t ex, input tag_t mem,
                                         input tag_t wb, input logic [4:0] r);
      if (hit(ex, r) && !ex.ld) return 2'd1;
      if (hit(mem, r))          return 2'd2;
      if (hit(wb, r))           return 2'd3;
      return 2'd0;
   endfunction

   always_comb begin
      running     = (state == RUN);
      // Once draining, the ECALL is older than anything in EX, so branches are ignored.
      br_eff      = br_jmp_flag & running;
      load_use    = ex_q.v & ex_q.ld &
                    ((id_rs1_used & hit(ex_q, id_rs1)) | (id_rs2_used & hit(ex_q, id_rs2)));
      stall_flag  = id_valid & (load_use | !running) & !br_eff;
      flush_id    = br_eff & id_valid;
      issue       = id_valid & !stall_flag & !flush_id & es_allowin;
      fwd_rs1_sel = fwd_of(ex_q, mem_q, wb_q, id_rs1);
      fwd_rs2_sel = fwd_of(ex_q, mem_q, wb_q, id_rs2);
      ex_d        = '0;
      if (issue) begin
         ex_d.v   = 1'b1;
         ex_d.rd  = id_rd;
         ex_d.wen = id_rd_wen & !id_ecall;
         ex_d.ld  = id_is_load;
      end
      // Emptiness judged on the tag values this edge will produce.
      drain_done  = es_allowin ? (!ex_q.v & !mem_q.v) : (!ex_q.v & !mem_q.v & !wb_q.v);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q   <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
         state  <= RUN;
         halted <= 1'b0;
      end else begin
         if (es_allowin) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
         end
         case (state)
            RUN:     if (issue && id_ecall) state <= DRAIN;
            DRAIN:   if (drain_done) begin
                        state  <= HALT;
                        halted <= 1'b1;
                     end
            HALT:    halted <= 1'b1;
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall_flag && (stall_cnt != '1))
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a tag-list model checked every cycle,
// plus literal expectations at key points; a CNT_W=4 copy checks saturation.
module tb_pipe_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_is_load, id_ecall;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       es_allowin, br_jmp_flag;
   logic       stall_flag, flush_id, issue, halted;
   logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
   logic [31:0] stall_cnt;
   logic       s4_stall, s4_flush, s4_issue, s4_halted;
   logic [1:0] s4_f1, s4_f2;
   logic [3:0] s4_cnt;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   bit          chk_en = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .id_ecall(id_ecall),
      .es_allowin(es_allowin), .br_jmp_flag(br_jmp_flag), .stall_flag(stall_flag),
      .flush_id(flush_id), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
      .issue(issue), .halted(halted), .stall_cnt(stall_cnt));

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .id_ecall(id_ecall),
      .es_allowin(es_allowin), .br_jmp_flag(br_jmp_flag), .stall_flag(s4_stall),
      .flush_id(s4_flush), .fwd_rs1_sel(s4_f1), .fwd_rs2_sel(s4_f2),
      .issue(s4_issue), .halted(s4_halted), .stall_cnt(s4_cnt));

   // Model: in-flight instructions as a 3-entry list (0=EX, 1=MEM, 2=WB).
   typedef struct {
      bit v;
      int rd;
      bit wen;
      bit ld;
   } mtag_t;

   mtag_t       pipe [3];
   bit          m_drain, m_halt;
   int unsigned m_stalls;
   bit          e_stall, e_flush, e_issue;
   int          e_f1, e_f2;

   function automatic bit writes(input mtag_t t, input int r);
      return t.v && t.wen && t.rd != 0 && t.rd == r;
   endfunction

   function automatic int src_of(input int r);
      for (int s = 0; s < 3; s++)
         if (writes(pipe[s], r) && !(s == 0 && pipe[0].ld)) return s + 1;
      return 0;
   endfunction

   task automatic model_eval();
      bit lu, run, br;
      lu  = pipe[0].ld && ((id_rs1_used && writes(pipe[0], int'(id_rs1))) ||
                           (id_rs2_used && writes(pipe[0], int'(id_rs2))));
      run = !m_drain && !m_halt;
      br  = br_jmp_flag && run;
      e_stall = id_valid && (lu || !run) && !br;
      e_flush = br && id_valid;
      e_issue = id_valid && !e_stall && !e_flush && es_allowin;
      e_f1    = src_of(int'(id_rs1));
      e_f2    = src_of(int'(id_rs2));
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
         m_drain = 0; m_halt = 0; m_stalls = 0;
      end else begin
         model_eval();
         if (e_stall) m_stalls++;
         if (e_issue && id_ecall) m_drain = 1;
         else begin
            if (es_allowin) begin
               pipe[2] = pipe[1];
               pipe[1] = pipe[0];
               pipe[0] = '{0, 0, 0, 0};
            end
            if (m_drain && !pipe[0].v && !pipe[1].v && !pipe[2].v) begin
               m_drain = 0; m_halt = 1;
            end
         end
         if (es_allowin && e_issue)
            pipe[0] = '{1, int'(id_rd), id_rd_wen && !id_ecall, id_is_load};
      end
   end

   task automatic cmp(input string nm, input longint act, input longint exp);
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         model_eval();
         vectors++;
         cmp("stall_flag", stall_flag, e_stall);
         cmp("flush_id", flush_id, e_flush);
         cmp("issue", issue, e_issue);
         cmp("fwd_rs1_sel", fwd_rs1_sel, e_f1);
         cmp("fwd_rs2_sel", fwd_rs2_sel, e_f2);
         cmp("halted", halted, m_halt);
         cmp("stall_cnt", stall_cnt, m_stalls);
         cmp("stall_cnt_w4", s4_cnt, (m_stalls > 15) ? 15 : m_stalls);
      end
   end

   task automatic lit(input string nm, input longint act, input longint exp);
      vectors++;
      cmp(nm, act, exp);
   endtask

   task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic wen, input logic ld, input logic ec,
                      input logic al, input logic br);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_ecall = ec;
      es_allowin = al; br_jmp_flag = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick(); tick();
      rst_n = 1'b1;
      chk_en = 1;
      #1;
      lit("rst_stall", stall_flag, 0);
      lit("rst_halted", halted, 0);
      lit("rst_cnt", stall_cnt, 0);
      lit("rst_fwd1", fwd_rs1_sel, 0);

      // back-to-back dependency through EX then MEM
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 1, 0);  lit("add_issue", issue, 1); tick();
      drv(1, 5, 0, 1, 0, 6, 1, 0, 0, 1, 0);
      lit("b2b_fwd1_ex", fwd_rs1_sel, 1); lit("b2b_stall", stall_flag, 0);
      lit("b2b_issue", issue, 1); tick();
      drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0);  lit("b2b_fwd1_mem", fwd_rs1_sel, 2); tick();
      idle(); idle(); idle();

      // load-use: one stall cycle then forward from MEM
      drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0);  tick();
      drv(1, 0, 7, 0, 1, 0, 0, 0, 0, 1, 0);
      lit("lu_stall", stall_flag, 1); lit("lu_issue0", issue, 0); tick();
      lit("lu_stall_off", stall_flag, 0); lit("lu_fwd2", fwd_rs2_sel, 2);
      lit("lu_issue1", issue, 1); lit("lu_cnt", stall_cnt, 1); tick();
      idle(); idle(); idle();

      // load writing x0 never matches
      drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);  tick();
      drv(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
      lit("x0_stall", stall_flag, 0); lit("x0_fwd1", fwd_rs1_sel, 0); tick();
      idle(); idle(); idle();

      // flush overrides load-use stall, EX gets a bubble
      drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0);  tick();
      drv(1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 1);
      lit("fl_stall", stall_flag, 0); lit("fl_flush", flush_id, 1);
      lit("fl_issue", issue, 0); tick();
      drv(1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      lit("fl_bubble_fwd1", fwd_rs1_sel, 2); lit("fl_bubble_stall", stall_flag, 0); tick();
      idle(); idle(); idle();

      // back-pressure: tags frozen for 4 cycles
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0);  tick();
      for (int i = 0; i < 4; i++) begin
         drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
         lit("bp_fwd1", fwd_rs1_sel, 1); lit("bp_issue", issue, 0);
         tick();
      end
      drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      lit("bp_fwd1_rel", fwd_rs1_sel, 1); lit("bp_issue_rel", issue, 1); tick();
      idle();

      // 20 frozen load-use stall cycles: 4-bit counter saturates
      drv(1, 0, 0, 0, 0, 8, 1, 1, 0, 1, 0);  tick();
      for (int i = 0; i < 20; i++) begin
         drv(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      lit("sat_cnt4", s4_cnt, 15);
      lit("sat_cnt32", stall_cnt, 21);
      drv(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0);  tick();
      idle(); idle(); idle();

      // ECALL behind two older instructions
      drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0); tick();
      drv(1, 0, 0, 0, 0, 11, 1, 0, 0, 1, 0); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  lit("ec_issue", issue, 1); tick();
      drv(1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         lit("drain_stall", stall_flag, 1); lit("drain_halted", halted, 0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         lit("halt_halted", halted, 1); lit("halt_stall", stall_flag, 1);
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      lit("post_rst_halted", halted, 0);
      lit("post_rst_stall", stall_flag, 0);
      lit("post_rst_cnt", stall_cnt, 0);
      idle(); idle();

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
